// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Next sequential PC; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(INSTR_BYTES);
    endfunction

    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage buses: imem request/response and decode-side valid/ready.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_rsp_valid;
    logic [INSTR_WIDTH-1:0] imem_rsp_data;
    logic                   if_valid;
    logic                   if_ready;
    logic [ADDR_WIDTH-1:0]  if_pc;
    logic [INSTR_WIDTH-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue of {pc, instr} entries with flush and same-cycle push/pop (also when full).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order imem requests,
// queues responses with their PCs, and flushes/drops in-flight words on redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           INSTR_WIDTH     = 32,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    instr_fetch_unit_if.master    bus
);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    // Queue entries use the package struct, so the widths must agree with it.
    if (ADDR_WIDTH != ADDR_W || INSTR_WIDTH != INSTR_W) begin : g_width_check
        $error("instr_fetch_unit: ADDR_WIDTH/INSTR_WIDTH must match fetch_pkg");
    end

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [OUT_W-1:0]      r_out_cnt;
    logic [OUT_W-1:0]      r_drop_cnt;
    logic                  r_active;

    logic [OUT_W-1:0]      w_live;
    logic [SUM_W-1:0]      w_credit_used;
    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_if_valid;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    fetch_entry_t          w_push_data;
    fetch_entry_t          w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_empty;
    logic                  w_full;

    // Issue credit: queued entries plus live in-flight words may never exceed the queue.
    assign w_live        = r_out_cnt - r_drop_cnt;
    assign w_credit_used = SUM_W'(w_count) + SUM_W'(w_live);
    assign w_req_valid   = r_active && !redirect_valid
                        && (r_out_cnt < OUT_W'(MAX_OUTSTANDING))
                        && (w_credit_used < SUM_W'(FIFO_DEPTH));
    assign w_accept      = w_req_valid && bus.imem_req_ready;

    assign w_drop        = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_push        = bus.imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_push_data   = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};
    assign w_if_valid    = !w_empty && !redirect_valid;
    assign w_pop         = w_if_valid && bus.if_ready;
    assign w_redirect_pc = pc_align(redirect_pc);

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_pc          = w_head.pc;
    assign bus.if_instr       = w_head.instr;
    assign fetch_pc           = r_fetch_pc;

    // PC, outstanding and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_active   <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_out_cnt <= r_out_cnt + OUT_W'(w_accept) - OUT_W'(bus.imem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                // A response landing in the redirect cycle is old-stream and already gone.
                r_drop_cnt <= r_out_cnt - OUT_W'(bus.imem_rsp_valid);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= pc_inc(r_fetch_pc);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - OUT_W'(1);
                end
                if (w_push) begin
                    r_rsp_pc <= pc_inc(r_rsp_pc);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.imem_rsp_valid && (r_out_cnt == '0)));
            assert (!(w_push && w_full && !w_pop));
            assert (r_drop_cnt <= r_out_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a behavioural imem and program-stream model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH      (32),
        .INSTR_WIDTH     (32),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;
    int rsp_pct = 100;
    int rdy_pct = 100;
    int dec_pct = 100;
    int xfer_cnt = 0;
    int accept_cnt = 0;

    logic [31:0]  pending[$];
    fetch_entry_t sb[$];
    logic [31:0]  sb_next;
    logic [31:0]  exp_req;
    fetch_entry_t mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function void sb_push_next();
        fetch_entry_t e;
        e.pc    = sb_next;
        e.instr = mem_word(sb_next);
        sb.push_back(e);
        sb_next = sb_next + 32'd4;
    endfunction

    // Program stream restarts at an aligned PC; both request and decode streams follow it.
    function void sb_restart(input logic [31:0] pc);
        sb.delete();
        sb_next = {pc[31:2], 2'b00};
        exp_req = sb_next;
        for (int i = 0; i < 8; i++) sb_push_next();
    endfunction

    task automatic redirect_now(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        sb_restart(pc);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect_now(pc);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Behavioural instruction memory: in-order responses, latency >= 1 cycle.
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.imem_rsp_valid = 1'b0;
                pending.delete();
            end else begin
                if (pending.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(pending.pop_front());
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                end
                bus.imem_req_ready = int'($urandom_range(99)) < rdy_pct;
            end
            #3;
            if (rst_n && bus.imem_req_valid) begin
                check("outstanding_limit",
                      64'((pending.size() + int'(bus.imem_rsp_valid)) < int'(MAXO)), 64'd1);
                if (bus.imem_req_ready) pending.push_back(bus.imem_req_addr);
            end
        end
    end

    initial begin
        bus.if_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.if_ready = int'($urandom_range(99)) < dec_pct;
        end
    end

    // Monitor: request address stream and decode transfers against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (redirect_valid)
                    check("quiet_in_redirect", {62'd0, bus.imem_req_valid, bus.if_valid}, 64'd0);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check("req_addr", bus.imem_req_addr, exp_req);
                    exp_req = exp_req + 32'd4;
                    accept_cnt++;
                end
                if (bus.if_valid && bus.if_ready) begin
                    xfer_cnt++;
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 64'd0, 64'd1);
                    end else begin
                        mon_e = sb.pop_front();
                        check("if_pc", bus.if_pc, mon_e.pc);
                        check("if_instr", bus.if_instr, mon_e.instr);
                    end
                    if (sb.size() < 8) sb_push_next();
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int x0;
        int a0;
        int waited;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sb_restart(RST_PC);
        #12;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_fetch_pc", fetch_pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Sustained throughput with single-cycle memory and ready decode.
        repeat (10) @(negedge clk);
        x0 = xfer_cnt;
        repeat (30) @(negedge clk);
        check("throughput", 64'(xfer_cnt - x0), 64'd30);

        // Decode stall: exactly FIFO_DEPTH words accepted, then issue stops.
        dec_pct = 0;
        do_redirect(32'h0);
        a0 = accept_cnt;
        repeat (15) @(negedge clk);
        check("stall_accepts", 64'(accept_cnt - a0), 64'd4);
        check("stall_req_low", bus.imem_req_valid, 0);
        check("stall_fetch_pc", fetch_pc, 32'h10);
        dec_pct = 100;
        repeat (12) @(negedge clk);

        // Redirect with two responses in flight.
        rsp_pct = 0;
        waited = 0;
        while (pending.size() < 2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("inflight_2", 64'(pending.size()), 64'd2);
        do_redirect(32'h103);
        check("redir_fetch_pc", fetch_pc, 32'h100);
        rsp_pct = 100;
        repeat (12) @(negedge clk);

        // Redirect coinciding with a response: that response is discarded.
        rsp_pct = 0;
        waited = 0;
        while (pending.size() < 2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("inflight_2b", 64'(pending.size()), 64'd2);
        @(posedge clk);
        #1 rsp_pct = 100;
        @(negedge clk);
        redirect_now(32'h200);
        #3 check("coincide_rsp", bus.imem_rsp_valid, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("coincide_drop_cnt", 64'(dut.r_drop_cnt), 64'd1);
        repeat (12) @(negedge clk);

        // Wrap around the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        x0 = xfer_cnt;
        repeat (20) @(negedge clk);
        check("wrap_progress", 64'(xfer_cnt - x0 >= 3), 64'd1);

        // Asynchronous reset mid-stream with a non-empty queue.
        dec_pct = 0;
        repeat (8) @(negedge clk);
        check("pre_rst_queue", bus.if_valid, 1);
        #1 rst_n = 1'b0;
        sb_restart(RST_PC);
        #1;
        check("midrst_req_valid", bus.imem_req_valid, 0);
        check("midrst_if_valid", bus.if_valid, 0);
        check("midrst_fetch_pc", fetch_pc, RST_PC);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        dec_pct = 100;
        repeat (20) @(negedge clk);

        // Randomized traffic with occasional (sometimes back-to-back) redirects.
        rsp_pct = 60;
        rdy_pct = 70;
        dec_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(39) == 0) begin
                if ($urandom_range(3) == 0) redirect_now(32'hFFFF_FFF0 | 32'($urandom_range(15)));
                else                        redirect_now($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        rsp_pct = 100;
        dec_pct = 100;
        repeat (30) @(negedge clk);
        check("random_progress", 64'(xfer_cnt > 500), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly downstream of the program counter. It owns the fetch address, issues in-order requests to instruction memory, and buffers the returned words with their PCs in a small queue. It presents {pc, instr} to decode over a valid/ready handshake. A redirect (taken branch, jump or trap) flushes the queue and discards any responses still in flight.

Parameters:
ADDR_WIDTH, 32, width of fetch/instruction addresses
INSTR_WIDTH, 32, instruction word width
FIFO_DEPTH, 4, fetch queue entries; power of 2, >=2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests; >=1
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch address; bits[1:0] ignored (forced to 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order; no backpressure
imem_rsp_data  in  INSTR_WIDTH  instruction word
if_valid  out  1  queue head valid to decode
if_ready  in  1  decode accepts head
if_pc  out  ADDR_WIDTH  PC of head instruction
if_instr  out  INSTR_WIDTH  head instruction
fetch_pc  out  ADDR_WIDTH  next address to be requested (debug/observability)

Behaviour:
- Reset (async): fetch_pc=RESET_PC; rsp_pc=RESET_PC; out_cnt=0; drop_cnt=0; queue empty.
- Outputs during and after reset, until the first issue: imem_req_valid=0, if_valid=0.
- Counters: out_cnt = accepted requests not yet answered. drop_cnt = in-flight responses to discard. live = out_cnt - drop_cnt.
- Issue condition:
  - imem_req_valid = !redirect_valid && out_cnt<MAX_OUTSTANDING && (count+live)<FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - This credit rule guarantees no response is ever lost for lack of queue space.
- Accept (imem_req_valid && imem_req_ready): fetch_pc += 4, modulo 2^ADDR_WIDTH (wraps 0xFFFFFFFC -> 0x0); out_cnt += 1.
- A request held without ready keeps a stable address. It may be withdrawn only by redirect.
- Response (imem_rsp_valid): out_cnt -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Else: push {rsp_pc, imem_rsp_data} to the queue; rsp_pc += 4 (same wrap rule).
- Redirect cycle:
  - imem_req_valid=0 and if_valid=0; any decode transfer that cycle is void.
  - Queue cleared.
  - fetch_pc and rsp_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - drop_cnt = out_cnt - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle belongs to the old stream and is discarded.
  - Issuing resumes the cycle after redirect, at the new address.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Latency: request accepted in cycle N, response earliest N+1, if_valid earliest N+2. There is no bypass path.
- Decode side: if_valid = !empty && !redirect_valid. Pop on if_valid && if_ready. Push and pop in the same cycle are allowed, including when full.
- Throughput: 1 instr/cycle sustained when imem responds in 1 cycle, MAX_OUTSTANDING>=2 and decode is always ready.
- Assertions:
  - imem_rsp_valid never arrives with out_cnt==0.
  - The queue never overflows.
  - drop_cnt <= out_cnt.

Decomposition:
- Package fetch_pkg: fetch_entry_t struct {pc, instr}; INSTR_BYTES=4; the PC-increment helper function.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush, count output and simultaneous push/pop.
- instr_fetch_unit holds the issue/credit, drop and PC logic.

Test Plan:
- Reset then ready=1, 1-cycle memory, decode ready: requests 0x0,0x4,0x8,…; if_pc/if_instr match memory in order; after warm-up one instr per cycle.
- Decode stalled (if_ready=0): queue fills to 4. imem_req_valid drops once count+live=4, with no lost or duplicated words. Releasing ready drains 0x0..0xC in order.
- Redirect to 0x103 with 2 responses in flight: both old responses are dropped. Next request is 0x100, and the first if_pc is 0x100.
- Redirect in the same cycle as imem_rsp_valid: that response is discarded; drop_cnt=out_cnt-1; no stale PC reaches decode.
- Redirect to 0xFFFFFFF8: fetch 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 with correct if_pc wrap.
- Async rst_n asserted mid-stream with the queue non-empty: outputs clear immediately. After release, fetch restarts at RESET_PC and responses to pre-reset requests are not injected by the bench.
